// File: rtl/version_pkg.sv
// ---------------------------------------------------------------------------
// version_pkg
// Build-version constants and the shared types used by the version reporter.
// The C_VERSION_* field values are placeholders that the build flow
// overwrites with the real bitstream stamp. Year and time fields are BCD.
// Also provides the responder's command/header bytes, payload length,
// FSM state type and a saturating-increment helper.
// ---------------------------------------------------------------------------
package version_pkg;

    localparam logic [7:0]  C_VERSION_MAJOR  = 8'h00;
    localparam logic [7:0]  C_VERSION_MINOR  = 8'h01;
    localparam logic [7:0]  C_VERSION_PATCH  = 8'h00;
    localparam logic [7:0]  C_VERSION_BUILD  = 8'h01;
    localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
    localparam logic [7:0]  C_VERSION_MONTH  = 8'h01;
    localparam logic [7:0]  C_VERSION_DAY    = 8'h01;
    localparam logic [7:0]  C_VERSION_HOUR   = 8'h00;
    localparam logic [7:0]  C_VERSION_MINUTE = 8'h00;
    localparam logic [7:0]  C_VERSION_SECOND = 8'h00;

    // Host request byte ('v') and frame header byte.
    localparam logic [7:0]  C_VERSION_CMD_BYTE    = 8'h76;
    localparam logic [7:0]  C_VERSION_HDR_BYTE    = 8'hA5;
    // Number of payload bytes between the header and the checksum.
    localparam logic [3:0]  C_VERSION_PAYLOAD_LEN = 4'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } vrep_state_t;

    // 8-bit increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/version_payload_mux.sv
// ---------------------------------------------------------------------------
// version_payload_mux
// Combinational lookup of one payload byte of the version frame. The field
// order on the wire is fixed here so the reporter FSM only deals in indices.
// Ports:
//   idx          in  4  payload byte index, 0..10 are meaningful
//   payload_byte out 8  selected payload byte (8'h00 for unused indices)
// ---------------------------------------------------------------------------
module version_payload_mux
    import version_pkg::*;
#(
    parameter logic [7:0]  VER_MAJOR  = C_VERSION_MAJOR,
    parameter logic [7:0]  VER_MINOR  = C_VERSION_MINOR,
    parameter logic [7:0]  VER_PATCH  = C_VERSION_PATCH,
    parameter logic [7:0]  VER_BUILD  = C_VERSION_BUILD,
    parameter logic [15:0] VER_YEAR   = C_VERSION_YEAR,
    parameter logic [7:0]  VER_MONTH  = C_VERSION_MONTH,
    parameter logic [7:0]  VER_DAY    = C_VERSION_DAY,
    parameter logic [7:0]  VER_HOUR   = C_VERSION_HOUR,
    parameter logic [7:0]  VER_MINUTE = C_VERSION_MINUTE,
    parameter logic [7:0]  VER_SECOND = C_VERSION_SECOND
) (
    input  logic [3:0] idx,
    output logic [7:0] payload_byte
);

    // Constant field selection; the year goes out high byte first.
    always_comb begin
        payload_byte = 8'h00;
        case (idx)
            4'd0:    payload_byte = VER_MAJOR;
            4'd1:    payload_byte = VER_MINOR;
            4'd2:    payload_byte = VER_PATCH;
            4'd3:    payload_byte = VER_BUILD;
            4'd4:    payload_byte = VER_YEAR[15:8];
            4'd5:    payload_byte = VER_YEAR[7:0];
            4'd6:    payload_byte = VER_MONTH;
            4'd7:    payload_byte = VER_DAY;
            4'd8:    payload_byte = VER_HOUR;
            4'd9:    payload_byte = VER_MINUTE;
            4'd10:   payload_byte = VER_SECOND;
            default: payload_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/version_reporter.sv
// ---------------------------------------------------------------------------
// version_reporter
// Answers a 'v' command byte from the host UART with a 13-byte frame:
// header, 11 version/date payload bytes, XOR checksum of the payload.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  asynchronous active-high reset
//   rx_data  in  8  received byte
//   rx_valid in  1  rx_data valid for one cycle (never back-pressured)
//   tx_data  out 8  byte to transmitter (registered)
//   tx_valid out 1  tx_data valid (registered)
//   tx_ready in  1  transmitter accepts when tx_valid && tx_ready
//   busy     out 1  frame in progress
//   done     out 1  one-cycle pulse after the checksum byte is accepted
//   req_cnt  out 8  frames started, wraps
//   drop_cnt out 8  requests ignored while busy, saturates at 255
// ---------------------------------------------------------------------------
module version_reporter
    import version_pkg::*;
#(
    parameter logic [7:0]  CMD_BYTE   = C_VERSION_CMD_BYTE,
    parameter logic [7:0]  HDR_BYTE   = C_VERSION_HDR_BYTE,
    parameter logic [7:0]  VER_MAJOR  = C_VERSION_MAJOR,
    parameter logic [7:0]  VER_MINOR  = C_VERSION_MINOR,
    parameter logic [7:0]  VER_PATCH  = C_VERSION_PATCH,
    parameter logic [7:0]  VER_BUILD  = C_VERSION_BUILD,
    parameter logic [15:0] VER_YEAR   = C_VERSION_YEAR,
    parameter logic [7:0]  VER_MONTH  = C_VERSION_MONTH,
    parameter logic [7:0]  VER_DAY    = C_VERSION_DAY,
    parameter logic [7:0]  VER_HOUR   = C_VERSION_HOUR,
    parameter logic [7:0]  VER_MINUTE = C_VERSION_MINUTE,
    parameter logic [7:0]  VER_SECOND = C_VERSION_SECOND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] req_cnt,
    output logic [7:0] drop_cnt
);

    vrep_state_t state_r, state_nxt_s;
    logic [3:0]  idx_r, idx_nxt_s;
    logic [7:0]  csum_r, csum_nxt_s;
    logic [7:0]  tx_data_r, tx_data_nxt_s;
    logic        tx_valid_r, tx_valid_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic [7:0]  req_cnt_r, req_cnt_nxt_s;
    logic [7:0]  drop_cnt_r, drop_cnt_nxt_s;

    logic        req_s;
    logic        hs_s;
    logic [3:0]  mux_idx_s;
    logic [7:0]  mux_byte_s;

    // The mux is always asked for the byte that goes out after the current
    // handshake, so tx_data can be loaded from it directly.
    version_payload_mux #(
        .VER_MAJOR  (VER_MAJOR),
        .VER_MINOR  (VER_MINOR),
        .VER_PATCH  (VER_PATCH),
        .VER_BUILD  (VER_BUILD),
        .VER_YEAR   (VER_YEAR),
        .VER_MONTH  (VER_MONTH),
        .VER_DAY    (VER_DAY),
        .VER_HOUR   (VER_HOUR),
        .VER_MINUTE (VER_MINUTE),
        .VER_SECOND (VER_SECOND)
    ) u_payload_mux (
        .idx          (mux_idx_s),
        .payload_byte (mux_byte_s)
    );

    assign req_s = rx_valid && (rx_data == CMD_BYTE);
    assign hs_s  = tx_valid_r && tx_ready;

    // Next-state, next-output and counter logic for the frame sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        csum_nxt_s     = csum_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        req_cnt_nxt_s  = req_cnt_r;
        mux_idx_s      = 4'd0;

        // Any request outside IDLE (including the checksum handshake cycle)
        // is a drop.
        if (req_s && (state_r != IDLE)) begin
            drop_cnt_nxt_s = sat_inc8(drop_cnt_r);
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end

        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_nxt_s    = HDR;
                    tx_data_nxt_s  = HDR_BYTE;
                    tx_valid_nxt_s = 1'b1;
                    busy_nxt_s     = 1'b1;
                    req_cnt_nxt_s  = req_cnt_r + 8'd1;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            HDR: begin
                mux_idx_s = 4'd0;
                if (hs_s) begin
                    state_nxt_s   = PAYLOAD;
                    idx_nxt_s     = 4'd0;
                    csum_nxt_s    = 8'h00;
                    tx_data_nxt_s = mux_byte_s;
                end else begin
                    state_nxt_s   = HDR;
                end
            end
            PAYLOAD: begin
                mux_idx_s = idx_r + 4'd1;
                if (hs_s) begin
                    // tx_data_r is the payload byte being accepted right now.
                    csum_nxt_s = csum_r ^ tx_data_r;
                    if (idx_r == (C_VERSION_PAYLOAD_LEN - 4'd1)) begin
                        state_nxt_s   = CSUM;
                        tx_data_nxt_s = csum_r ^ tx_data_r;
                    end else begin
                        idx_nxt_s     = idx_r + 4'd1;
                        tx_data_nxt_s = mux_byte_s;
                    end
                end else begin
                    state_nxt_s = PAYLOAD;
                end
            end
            CSUM: begin
                if (hs_s) begin
                    state_nxt_s    = IDLE;
                    tx_data_nxt_s  = 8'h00;
                    tx_valid_nxt_s = 1'b0;
                    busy_nxt_s     = 1'b0;
                    done_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s    = CSUM;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                tx_valid_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears any frame in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= 4'd0;
            csum_r     <= 8'h00;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            req_cnt_r  <= 8'd0;
            drop_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            csum_r     <= csum_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            req_cnt_r  <= req_cnt_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign req_cnt  = req_cnt_r;
    assign drop_cnt = drop_cnt_r;

endmodule
